// File: rtl/hssi_kpi_monitor.sv
// hssi_kpi_monitor
//   Passive KPI tap on the HE-HSSI user-clock AXI-Stream path. It watches
//   each transfer without driving the stream. It counts completed packets,
//   payload bytes, length mismatches and sink-flagged errors. It also
//   measures the cycle window from the first beat to the final EOP, which
//   software uses to compute achieved throughput.
//
// Ports
//   clk, rst              user clock, asynchronous active-high reset
//   start                 one-cycle pulse: clear all counters and arm
//   num_pkt_exp           packet count that completes a measurement
//   pkt_len_exp           expected bytes per packet
//   len_chk_en            enable per-packet length check
//   axis_tvalid/tready    tapped handshake (beat = tvalid & tready)
//   axis_tdata            tapped data (not inspected)
//   axis_tkeep            byte enables, need not be contiguous
//   axis_tlast            end of packet
//   axis_tuser_err        sink error flag, sampled on the tlast beat
//   busy / done / timeout measurement status
//   pkt_cnt, byte_cnt, cycle_cnt, len_err_cnt, usr_err_cnt   saturating KPIs
module hssi_kpi_monitor #(
  parameter int DATA_W      = 64,
  parameter int PKT_CNT_W   = 32,
  parameter int WIDE_CNT_W  = 48,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           num_pkt_exp,
  input  logic [15:0]           pkt_len_exp,
  input  logic                  len_chk_en,
  input  logic                  axis_tvalid,
  input  logic                  axis_tready,
  input  logic [DATA_W-1:0]     axis_tdata,
  input  logic [DATA_W/8-1:0]   axis_tkeep,
  input  logic                  axis_tlast,
  input  logic                  axis_tuser_err,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [PKT_CNT_W-1:0]  pkt_cnt,
  output logic [WIDE_CNT_W-1:0] byte_cnt,
  output logic [WIDE_CNT_W-1:0] cycle_cnt,
  output logic [PKT_CNT_W-1:0]  len_err_cnt,
  output logic [PKT_CNT_W-1:0]  usr_err_cnt
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int BCNT_W = $clog2(KEEP_W + 1);
  // One bit wider than pkt_len_exp so a saturated accumulator can never
  // alias a legal expected length.
  localparam int PB_W   = 17;
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam int CMP_W  = (PKT_CNT_W > 32) ? PKT_CNT_W : 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [PKT_CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [WIDE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [WIDE_CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [WIDE_CNT_W-1:0] eop_cyc_q, eop_cyc_d;
  logic [PKT_CNT_W-1:0]  len_err_q, len_err_d;
  logic [PKT_CNT_W-1:0]  usr_err_q, usr_err_d;
  logic [PB_W-1:0]       pkt_bytes_q, pkt_bytes_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic                  timeout_q, timeout_d;

  logic                  beat;
  logic [BCNT_W-1:0]     beat_bytes;
  logic [PKT_CNT_W-1:0]  pkt_new;
  logic [PB_W-1:0]       pkt_sum;
  logic [IDLE_W-1:0]     idle_inc;

  // tdata carries no KPI information; the tap only needs its presence.
  logic unused_tdata;
  assign unused_tdata = ^axis_tdata;

  function automatic logic [WIDE_CNT_W-1:0] sat_add_wide(
    input logic [WIDE_CNT_W-1:0] a,
    input logic [BCNT_W-1:0]     b
  );
    logic [WIDE_CNT_W:0] s;
    s = {1'b0, a} + {{(WIDE_CNT_W + 1 - BCNT_W){1'b0}}, b};
    return s[WIDE_CNT_W] ? {WIDE_CNT_W{1'b1}} : s[WIDE_CNT_W-1:0];
  endfunction

  function automatic logic [PB_W-1:0] sat_add_pb(
    input logic [PB_W-1:0]   a,
    input logic [BCNT_W-1:0] b
  );
    logic [PB_W:0] s;
    s = {1'b0, a} + {{(PB_W + 1 - BCNT_W){1'b0}}, b};
    return s[PB_W] ? {PB_W{1'b1}} : s[PB_W-1:0];
  endfunction

  function automatic logic [PKT_CNT_W-1:0] sat_inc(input logic [PKT_CNT_W-1:0] a);
    return (a == {PKT_CNT_W{1'b1}}) ? a : a + {{(PKT_CNT_W - 1){1'b0}}, 1'b1};
  endfunction

  assign beat = axis_tvalid & axis_tready;

  // Popcount of tkeep; holes in the mask are legal.
  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      beat_bytes = beat_bytes + {{(BCNT_W - 1){1'b0}}, axis_tkeep[i]};
    end
  end

  always_comb begin
    state_d     = state_q;
    pkt_cnt_d   = pkt_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    eop_cyc_d   = eop_cyc_q;
    len_err_d   = len_err_q;
    usr_err_d   = usr_err_q;
    pkt_bytes_d = pkt_bytes_q;
    idle_d      = idle_q;
    timeout_d   = timeout_q;

    pkt_new  = sat_inc(pkt_cnt_q);
    pkt_sum  = sat_add_pb(pkt_bytes_q, beat_bytes);
    idle_inc = idle_q + {{(IDLE_W - 1){1'b0}}, 1'b1};

    case (state_q)
      S_ARMED, S_MEASURE: begin
        // In ARMED only the first beat opens the window; it counts as cycle 1.
        if (state_q == S_MEASURE || beat) begin
          state_d     = S_MEASURE;
          cycle_cnt_d = sat_add_wide(cycle_cnt_q, {{(BCNT_W - 1){1'b0}}, 1'b1});
          if (beat) begin
            idle_d      = '0;
            byte_cnt_d  = sat_add_wide(byte_cnt_q, beat_bytes);
            pkt_bytes_d = pkt_sum;
            if (axis_tlast) begin
              pkt_cnt_d   = pkt_new;
              pkt_bytes_d = '0;
              // Remember the window end so a later timeout can roll back to it.
              eop_cyc_d   = cycle_cnt_d;
              if (len_chk_en && (pkt_sum != {1'b0, pkt_len_exp})) begin
                len_err_d = sat_inc(len_err_q);
              end
              if (axis_tuser_err) begin
                usr_err_d = sat_inc(usr_err_q);
              end
              if (CMP_W'(pkt_new) == CMP_W'(num_pkt_exp)) begin
                state_d = S_DONE;
              end
            end
          end else begin
            idle_d = idle_inc;
            if (idle_inc == IDLE_W'(TIMEOUT_CYC)) begin
              state_d     = S_DONE;
              timeout_d   = 1'b1;
              cycle_cnt_d = eop_cyc_q;
            end
          end
        end
      end
      default: begin
      end
    endcase

    // start wins in every state and swallows any coincident beat.
    if (start) begin
      pkt_cnt_d   = '0;
      byte_cnt_d  = '0;
      cycle_cnt_d = '0;
      eop_cyc_d   = '0;
      len_err_d   = '0;
      usr_err_d   = '0;
      pkt_bytes_d = '0;
      idle_d      = '0;
      timeout_d   = 1'b0;
      state_d     = (num_pkt_exp == 32'd0) ? S_DONE : S_ARMED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pkt_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      eop_cyc_q   <= '0;
      len_err_q   <= '0;
      usr_err_q   <= '0;
      pkt_bytes_q <= '0;
      idle_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pkt_cnt_q   <= pkt_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      eop_cyc_q   <= eop_cyc_d;
      len_err_q   <= len_err_d;
      usr_err_q   <= usr_err_d;
      pkt_bytes_q <= pkt_bytes_d;
      idle_q      <= idle_d;
      timeout_q   <= timeout_d;
    end
  end

  assign busy        = (state_q == S_ARMED) || (state_q == S_MEASURE);
  assign done        = (state_q == S_DONE);
  assign timeout     = timeout_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign byte_cnt    = byte_cnt_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign len_err_cnt = len_err_q;
  assign usr_err_cnt = usr_err_q;

endmodule

// File: tb/tb_hssi_kpi_monitor.sv
// Bench for hssi_kpi_monitor: table-driven scenarios, hand-written corner
// sequences and randomized traffic checked against a stream-log model.
module tb_hssi_kpi_monitor;

  localparam int DATA_W      = 64;
  localparam int PKT_CNT_W   = 32;
  localparam int WIDE_CNT_W  = 48;
  localparam int TIMEOUT_CYC = 4096;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [31:0]           num_pkt_exp;
  logic [15:0]           pkt_len_exp;
  logic                  len_chk_en;
  logic                  axis_tvalid;
  logic                  axis_tready;
  logic [DATA_W-1:0]     axis_tdata;
  logic [DATA_W/8-1:0]   axis_tkeep;
  logic                  axis_tlast;
  logic                  axis_tuser_err;
  logic                  busy;
  logic                  done;
  logic                  timeout;
  logic [PKT_CNT_W-1:0]  pkt_cnt;
  logic [WIDE_CNT_W-1:0] byte_cnt;
  logic [WIDE_CNT_W-1:0] cycle_cnt;
  logic [PKT_CNT_W-1:0]  len_err_cnt;
  logic [PKT_CNT_W-1:0]  usr_err_cnt;

  always #5 clk = ~clk;

  hssi_kpi_monitor #(
    .DATA_W(DATA_W), .PKT_CNT_W(PKT_CNT_W), .WIDE_CNT_W(WIDE_CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_pkt_exp(num_pkt_exp), .pkt_len_exp(pkt_len_exp),
    .len_chk_en(len_chk_en), .axis_tvalid(axis_tvalid), .axis_tready(axis_tready),
    .axis_tdata(axis_tdata), .axis_tkeep(axis_tkeep), .axis_tlast(axis_tlast),
    .axis_tuser_err(axis_tuser_err), .busy(busy), .done(done), .timeout(timeout),
    .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt), .cycle_cnt(cycle_cnt),
    .len_err_cnt(len_err_cnt), .usr_err_cnt(usr_err_cnt)
  );

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  bit done_early;

  // Log of every accepted beat; the model works only from this log.
  typedef struct {
    int cyc;
    int nbytes;
    bit last;
    bit err;
  } beat_t;
  beat_t beats[$];

  typedef struct {
    string name;
    int    num_exp;
    int    len_exp;
    bit    chk;
    int    n_pkts;
    int    bp;        // 0 none, 1 tready low every 4th cycle, 2 random
    int    short_idx; // packet sent one byte short (-1 none)
    int    usr_idx;   // packet with tuser_err on tlast (-1 none)
    int    e_pkt;
    int    e_byte;
    int    e_cyc;     // -1: use the window measured from the beat log
    int    e_lerr;
    int    e_uerr;
    bit    e_tmo;
  } scen_t;
  scen_t tbl[5];

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive_beat(input logic [7:0] keep, input bit last, input bit err, input int bp);
    bit sent;
    sent = 1'b0;
    while (!sent) begin
      axis_tvalid    = (bp == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      axis_tready    = (bp == 1) ? (((cyc + 1) % 4) != 0) :
                       (bp == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      axis_tkeep     = keep;
      axis_tlast     = last;
      axis_tuser_err = err;
      axis_tdata     = {$urandom, $urandom};
      if (done) done_early = 1'b1;
      tick();
      if (axis_tvalid && axis_tready) begin
        sent = 1'b1;
        beats.push_back(beat_t'{cyc, $countones(keep), last, err});
      end
    end
    axis_tvalid = 1'b0;
  endtask

  task automatic send_packet(input int len, input bit err, input bit rnd, input int bp);
    int rem;
    rem = len;
    while (rem > 0) begin
      int k;
      logic [7:0] keep;
      k = rnd ? int'($urandom_range(1, 8)) : 8;
      if (k > rem) k = rem;
      keep = '0;
      if (rnd) begin
        while ($countones(keep) < k) keep[$urandom_range(0, 7)] = 1'b1;
      end else begin
        for (int i = 0; i < k; i++) keep[i] = 1'b1;
      end
      rem -= k;
      drive_beat(keep, rem == 0, err, bp);
    end
  endtask

  // Expected KPIs from the beat log: totals, per-packet lengths, and the
  // window from the first logged beat to the last logged EOP.
  task automatic model(input int num_exp, input int len_exp, input bit chk,
                       output int e_pkt, output int e_byte, output int e_cyc,
                       output int e_lerr, output int e_uerr, output bit e_tmo);
    int pb;
    int last_eop;
    pb = 0; last_eop = 0;
    e_pkt = 0; e_byte = 0; e_lerr = 0; e_uerr = 0;
    foreach (beats[i]) begin
      e_byte += beats[i].nbytes;
      pb     += beats[i].nbytes;
      if (beats[i].last) begin
        e_pkt++;
        if (chk && pb != len_exp) e_lerr++;
        if (beats[i].err) e_uerr++;
        pb = 0;
        last_eop = beats[i].cyc;
      end
    end
    e_cyc = (e_pkt == 0) ? 0 : last_eop - beats[0].cyc + 1;
    e_tmo = (e_pkt != num_exp);
  endtask

  task automatic run(input string tag, input int num_exp, input int len_exp, input bit chk,
                     input int n_pkts, input int bp, input bit rnd, input int short_idx,
                     input int usr_idx, input bit do_start);
    int idle;
    beats.delete();
    done_early  = 1'b0;
    num_pkt_exp = 32'(num_exp);
    pkt_len_exp = 16'(len_exp);
    len_chk_en  = chk;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, " busy_after_start"}, 64'(busy), 1);
      check({tag, " bytes_cleared"}, 64'(byte_cnt), 0);
    end
    for (int p = 0; p < n_pkts; p++) begin
      int len;
      bit err;
      if (rnd) begin
        len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : len_exp;
        err = ($urandom_range(0, 4) == 0);
      end else begin
        len = (p == short_idx) ? len_exp - 1 : len_exp;
        err = (p == usr_idx);
      end
      send_packet(len, err, rnd, bp);
    end
    axis_tlast     = 1'b0;
    axis_tuser_err = 1'b0;
    if (n_pkts >= num_exp) begin
      check({tag, " done_before_final_eop"}, 64'(done_early), 0);
      check({tag, " done_cycle_after_eop"}, 64'(done), 1);
    end else begin
      idle = 0;
      while (done !== 1'b1 && idle < TIMEOUT_CYC + 16) begin
        tick();
        idle++;
      end
      check({tag, " timeout_latency"}, 64'(idle), 64'(TIMEOUT_CYC));
    end
    check({tag, " busy_at_done"}, 64'(busy), 0);
  endtask

  task automatic check_counts(input string tag, input int e_pkt, input int e_byte, input int e_cyc,
                              input int e_lerr, input int e_uerr, input bit e_tmo);
    check({tag, " pkt_cnt"}, 64'(pkt_cnt), 64'(e_pkt));
    check({tag, " byte_cnt"}, 64'(byte_cnt), 64'(e_byte));
    check({tag, " cycle_cnt"}, 64'(cycle_cnt), 64'(e_cyc));
    check({tag, " len_err_cnt"}, 64'(len_err_cnt), 64'(e_lerr));
    check({tag, " usr_err_cnt"}, 64'(usr_err_cnt), 64'(e_uerr));
    check({tag, " timeout"}, 64'(timeout), 64'(e_tmo));
    check({tag, " done"}, 64'(done), 1);
    $display("run %s: pkts=%0d bytes=%0d cycles=%0d len_err=%0d usr_err=%0d timeout=%0d",
             tag, pkt_cnt, byte_cnt, cycle_cnt, len_err_cnt, usr_err_cnt, timeout);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " pkt_cnt"}, 64'(pkt_cnt), 0);
    check({tag, " byte_cnt"}, 64'(byte_cnt), 0);
    check({tag, " cycle_cnt"}, 64'(cycle_cnt), 0);
    check({tag, " len_err_cnt"}, 64'(len_err_cnt), 0);
    check({tag, " usr_err_cnt"}, 64'(usr_err_cnt), 0);
    check({tag, " timeout"}, 64'(timeout), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_pkt, e_byte, e_cyc, e_lerr, e_uerr;
    bit e_tmo;

    rst = 1'b1; start = 1'b0; num_pkt_exp = 32'd0; pkt_len_exp = 16'd0; len_chk_en = 1'b0;
    axis_tvalid = 1'b0; axis_tready = 1'b0; axis_tdata = '0; axis_tkeep = '0;
    axis_tlast = 1'b0; axis_tuser_err = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    check("reset busy", 64'(busy), 0);
    check("reset done", 64'(done), 0);
    rst = 1'b0;
    // Beats in IDLE are ignored.
    drive_beat(8'hFF, 1'b1, 1'b0, 0);
    check("idle_beat byte_cnt", 64'(byte_cnt), 0);
    check("idle_beat busy", 64'(busy), 0);

    tbl[0] = '{"default",    128, 132, 1'b1, 128, 0, -1, -1, 128, 16896, 2176, 0, 0, 1'b0};
    tbl[1] = '{"backpress",  128, 132, 1'b1, 128, 1, -1, -1, 128, 16896,   -1, 0, 0, 1'b0};
    tbl[2] = '{"errors",     128, 132, 1'b1, 128, 0,  5,  9, 128, 16895, 2176, 1, 1, 1'b0};
    tbl[3] = '{"errors_nochk",128,132, 1'b0, 128, 0,  5,  9, 128, 16895, 2176, 0, 1, 1'b0};
    tbl[4] = '{"timeout",    128, 132, 1'b1,  10, 0, -1, -1,  10,  1320,  170, 0, 0, 1'b1};

    foreach (tbl[i]) begin
      run(tbl[i].name, tbl[i].num_exp, tbl[i].len_exp, tbl[i].chk, tbl[i].n_pkts, tbl[i].bp,
          1'b0, tbl[i].short_idx, tbl[i].usr_idx, 1'b1);
      e_cyc = tbl[i].e_cyc;
      if (e_cyc < 0) begin
        model(tbl[i].num_exp, tbl[i].len_exp, tbl[i].chk, e_pkt, e_byte, e_cyc, e_lerr, e_uerr, e_tmo);
        check({tbl[i].name, " window_gt_2176"}, 64'(cycle_cnt > 48'd2176), 1);
      end
      check_counts(tbl[i].name, tbl[i].e_pkt, tbl[i].e_byte, e_cyc, tbl[i].e_lerr,
                   tbl[i].e_uerr, tbl[i].e_tmo);
    end

    // DONE holds while more beats arrive.
    drive_beat(8'hFF, 1'b0, 1'b0, 0);
    drive_beat(8'h0F, 1'b1, 1'b1, 0);
    check("done_hold byte_cnt", 64'(byte_cnt), 1320);
    check("done_hold pkt_cnt", 64'(pkt_cnt), 10);
    check("done_hold done", 64'(done), 1);

    // num_pkt_exp = 0 completes immediately with cleared counters.
    num_pkt_exp = 32'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_exp done", 64'(done), 1);
    check("zero_exp busy", 64'(busy), 0);
    check_all_zero("zero_exp");
    $display("run zero_exp: done=%0d pkts=%0d", done, pkt_cnt);

    // First beat in ARMED is counted and opens the window at 1.
    num_pkt_exp = 32'd128; pkt_len_exp = 16'd132; len_chk_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    drive_beat(8'hFF, 1'b0, 1'b0, 0);
    check("first_beat cycle_cnt", 64'(cycle_cnt), 1);
    check("first_beat byte_cnt", 64'(byte_cnt), 8);
    check("first_beat busy", 64'(busy), 1);
    $display("run first_beat: cycles=%0d bytes=%0d", cycle_cnt, byte_cnt);

    // Restart during packet 3 with a coincident beat, then a full run.
    start = 1'b1;
    tick();
    start = 1'b0;
    send_packet(132, 1'b0, 1'b0, 0);
    send_packet(132, 1'b0, 1'b0, 0);
    for (int b = 0; b < 5; b++) drive_beat(8'hFF, 1'b0, 1'b0, 0);
    start = 1'b1; axis_tvalid = 1'b1; axis_tready = 1'b1; axis_tkeep = 8'hFF; axis_tlast = 1'b0;
    tick();
    start = 1'b0; axis_tvalid = 1'b0;
    check("restart busy", 64'(busy), 1);
    check("restart done", 64'(done), 0);
    check_all_zero("restart");
    run("restart_full", 128, 132, 1'b1, 128, 0, 1'b0, -1, -1, 1'b0);
    check_counts("restart_full", 128, 16896, 2176, 0, 0, 1'b0);

    // Asynchronous reset in the middle of a measurement.
    start = 1'b1;
    tick();
    start = 1'b0;
    send_packet(132, 1'b0, 1'b0, 0);
    send_packet(132, 1'b0, 1'b0, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst busy", 64'(busy), 0);
    check("async_rst done", 64'(done), 0);
    check_all_zero("async_rst");
    $display("run async_rst: busy=%0d pkts=%0d bytes=%0d", busy, pkt_cnt, byte_cnt);
    @(negedge clk);
    rst = 1'b0;

    // Random traffic with noncontiguous tkeep and random handshakes.
    for (int r = 0; r < 6; r++) begin
      int num, len, npk;
      bit chk;
      string tag;
      num = (r == 5) ? int'($urandom_range(2, 6)) : int'($urandom_range(1, 6));
      len = $urandom_range(4, 40);
      chk = $urandom_range(0, 1) != 0;
      npk = (r == 5) ? num - 1 : num;
      tag = $sformatf("random%0d", r);
      run(tag, num, len, chk, npk, 2, 1'b1, -1, -1, 1'b1);
      model(num, len, chk, e_pkt, e_byte, e_cyc, e_lerr, e_uerr, e_tmo);
      check_counts(tag, e_pkt, e_byte, e_cyc, e_lerr, e_uerr, e_tmo);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hssi_kpi_monitor.md
Name: hssi_kpi_monitor

Overview:
- Passive throughput monitor on the HE-HSSI user-clock AXI-Stream path.
- Sits directly downstream of the traffic generator's packet output. Taps each beat without affecting the stream.
- Counts packets, payload bytes, length/error events, and the cycle window from the first beat to the final EOP.
- Software and the bench derive achieved Gbps from these values and compare against theoretical line-rate throughput.

Parameters:
DATA_W, 64, tdata width in bits (multiple of 8)
PKT_CNT_W, 32, width of packet and error counters
WIDE_CNT_W, 48, width of byte and cycle counters
TIMEOUT_CYC, 4096, idle cycles in MEASURE before forced DONE

Ports:
clk  in  1  HE-HSSI user clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse: clear all counters and arm
num_pkt_exp  in  32  expected packet count (e.g. 0x80)
pkt_len_exp  in  16  expected bytes per packet (e.g. 0x84)
len_chk_en  in  1  1 = check each packet length against pkt_len_exp
axis_tvalid  in  1  tapped valid
axis_tready  in  1  tapped ready
axis_tdata  in  DATA_W  tapped data (unused except for parity of width)
axis_tkeep  in  DATA_W/8  byte enables
axis_tlast  in  1  end of packet
axis_tuser_err  in  1  sink-flagged packet error, sampled on tlast beat
busy  out  1  high in ARMED or MEASURE
done  out  1  high in DONE
timeout  out  1  DONE was reached via idle timeout
pkt_cnt  out  PKT_CNT_W  completed packets
byte_cnt  out  WIDE_CNT_W  total bytes, sum of popcount(tkeep) over all beats
cycle_cnt  out  WIDE_CNT_W  cycles from first beat to last EOP, inclusive
len_err_cnt  out  PKT_CNT_W  packets whose length differs from pkt_len_exp
usr_err_cnt  out  PKT_CNT_W  packets with tuser_err on tlast

Behaviour:
- Beat definition: beat = axis_tvalid & axis_tready. Nothing else is qualified.
- Reset: state IDLE; all outputs 0.
- States:
  - IDLE: start moves to ARMED and clears counters, timeout, and the per-packet byte accumulator. Beats are ignored.
  - ARMED: the first beat moves to MEASURE. That beat is counted, and cycle_cnt becomes 1.
  - MEASURE: cycle_cnt increments every cycle. Beats update the counters.
    - On a tlast beat, pkt_cnt increments. If the new pkt_cnt equals num_pkt_exp, move to DONE. cycle_cnt then holds the value including this cycle.
    - idle_ctr counts consecutive cycles without a beat and clears on any beat. When it reaches TIMEOUT_CYC, move to DONE with timeout=1. cycle_cnt is then rolled back to the value latched at the last tlast beat.
  - DONE: outputs hold. Beats are ignored. start moves to ARMED and clears as in IDLE.
- Start priority:
  - start has priority in every state. In ARMED or MEASURE it restarts the measurement (clear counters, move to ARMED).
  - A beat coincident with start is discarded.
- num_pkt_exp = 0: start moves straight to DONE on the next cycle with all counters 0 and timeout=0.
- Per-packet length:
  - pkt_bytes accumulates popcount(tkeep) and clears after each tlast.
  - On a tlast beat, if len_chk_en and (pkt_bytes + this beat's bytes) != pkt_len_exp, len_err_cnt increments.
  - usr_err_cnt increments when axis_tuser_err=1 on a tlast beat.
- Arithmetic:
  - All counters saturate at all-ones and never wrap.
  - Byte popcount is computed combinationally per beat.
  - tkeep is not required to be contiguous.
- Latency: all outputs are registered and reflect a beat on the cycle after it. done rises the cycle after the final EOP beat.
- Backpressure: beats with tvalid=1, tready=0 are not counted. Those cycles still count in cycle_cnt and in idle_ctr.

Test Plan:
- Default traffic: start, num_pkt_exp=0x80, pkt_len_exp=0x84, len_chk_en=1. Send 128 back-to-back packets of 132B on the 64-bit bus (17 beats each, last tkeep=0x0F). Required: pkt_cnt=128, byte_cnt=16896, cycle_cnt=2176, len_err_cnt=0, done=1 one cycle after the final tlast, timeout=0.
- Gap/backpressure: same traffic with tready low every 4th cycle. Required: byte_cnt=16896, pkt_cnt=128, cycle_cnt equal to the bench-counted window (>2176), no timeout.
- Length and user errors: packet 5 is 131B and packet 9 has tuser_err=1 on tlast. Required: len_err_cnt=1, usr_err_cnt=1, pkt_cnt=128. With len_chk_en=0, len_err_cnt=0.
- Timeout: num_pkt_exp=0x80, send only 10 packets, then idle. Required: done and timeout=1 exactly TIMEOUT_CYC cycles after the last beat, pkt_cnt=10, cycle_cnt=170.
- Restart mid-run: start during packet 3 while a beat is coincident. Required: next cycle busy=1 with all counters 0. A subsequent full run gives the same results as the default-traffic scenario.
- Edge cases:
  - num_pkt_exp=0: done=1 one cycle after start with all counters 0.
  - Asserting rst mid-MEASURE: all outputs 0 immediately.
